// File: rtl/fetch_pkg.sv
// Shared types and helpers for the RV32I fetch stage: the buffered fetch entry,
// the canonical NOP encoding and the occupancy-counter width rule.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  // Counters must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem request/response channels, execute redirect and the
// decode handoff. The fetch unit takes the master side.
interface fetch_unit_if #(parameter int XLEN = 32);

  // Handshakes: a transfer happens on a cycle where valid && ready; the
  // sender holds payload stable while valid && !ready, except that a redirect
  // may withdraw a pending imem request. Responses have no backpressure.
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; flush overrides push and pop.
// The caller never pushes when full nor pops when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  data_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I stage-1 fetch: owns the PC, issues imem word requests, buffers responses
// for decode and squashes wrong-path responses after a redirect.
// Optional FETCH_PERF_CNT_EN adds bubble and redirect performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = FETCH_XLEN,
  parameter logic [XLEN-1:0] PC_RESET   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam int CW = cnt_width(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_use;
  logic            req_fire, rsp_take, push, pop, id_valid;
  fetch_entry_t    head, push_entry;

  // Issue is capped so every outstanding request has a FIFO slot waiting.
  assign in_use             = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (in_use < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_take   = bus.imem_rsp_valid && (outstanding_q != '0);
  assign push       = rsp_take && !bus.redirect_valid && (drop_cnt_q == '0);
  assign push_entry = '{pc: rsp_pc_q, instr: bus.imem_rsp_data};

  assign id_valid     = (fifo_count != '0) && !bus.redirect_valid;
  assign pop          = id_valid && bus.id_ready;
  assign bus.id_valid = id_valid;
  assign bus.id_instr = head.instr;
  assign bus.id_pc    = head.pc;

  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    if (bus.redirect_valid) begin
      // Whatever is still in flight after this cycle belongs to the old path.
      pc_d       = {bus.redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_d   = {bus.redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt_d = outstanding_q - CW'(rsp_take);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (rsp_take) begin
        if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
        else                  rsp_pc_d   = rsp_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= PC_RESET;
      rsp_pc_q      <= PC_RESET;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (fifo_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic        redirect_q;
  logic [31:0] bubble_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_q     <= 1'b0;
      bubble_cnt_q   <= '0;
      redirect_cnt_q <= '0;
    end else begin
      redirect_q <= bus.redirect_valid;
      if (bus.id_ready && !id_valid)          bubble_cnt_q   <= bubble_cnt_q + 32'd1;
      if (bus.redirect_valid && !redirect_q)  redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign perf_bubble_cnt   = bubble_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding is a memory-side protocol error.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.imem_rsp_valid && (outstanding_q == '0)))
        else $warning("fetch_unit: imem response with no outstanding request ignored");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with variable latency,
// an epoch-based reference of which instructions decode must see, and directed
// plus randomized scenarios.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt, perf_redirect_cnt;
`endif

  fetch_unit #(.XLEN(32), .PC_RESET(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_bubble_cnt   (perf_bubble_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mq[$];      // requests accepted by memory, oldest first
  logic [31:0] exp_q[$];   // PCs decode is owed, in order
  logic [31:0] next_pc;
  int          epoch, cyc, lat;
  int          errors, checks;
  logic        spurious;
  logic        last_acc, last_pop, last_rv;
  logic [31:0] last_acc_addr, last_pop_pc;
  int          first_acc, first_valid;
  int          exp_bubble, exp_redir;
  logic        prev_redir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: present memory response, check outputs, advance the model.
  task automatic step();
    logic        rv, exp_rv, exp_iv, acc, pop, redir;
    logic [31:0] acc_addr;
    req_t        e, r;
    rv = 1'b0;
    if (spurious) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hBAD0_BAD0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    redir  = bus.redirect_valid;
    exp_rv = !redir && (mq.size() + exp_q.size() < DEPTH);
    exp_iv = !redir && (exp_q.size() > 0);
    checks++;
    if (bus.imem_req_valid !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      checks++;
      if (bus.imem_req_addr !== next_pc) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_req_addr, next_pc);
      end
    end
    checks++;
    if (bus.id_valid !== exp_iv) begin
      errors++;
      $display("FAIL id_valid cyc=%0d got=%b exp=%b", cyc, bus.id_valid, exp_iv);
    end
    if (exp_iv) begin
      checks++;
      if (bus.id_pc !== exp_q[0] || bus.id_instr !== mem_word(exp_q[0])) begin
        errors++;
        $display("FAIL id_entry cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                 cyc, bus.id_pc, bus.id_instr, exp_q[0], mem_word(exp_q[0]));
      end
    end
    acc      = bus.imem_req_valid && bus.imem_req_ready;
    acc_addr = bus.imem_req_addr;
    pop      = bus.id_valid && bus.id_ready;
    if (bus.id_ready && !exp_iv) exp_bubble++;
    if (redir && !prev_redir) exp_redir++;
    prev_redir = redir;
    if (acc && first_acc < 0) first_acc = cyc;
    if (exp_iv && first_valid < 0) first_valid = cyc;
    last_acc = acc; last_acc_addr = acc_addr;
    last_pop = pop; last_pop_pc = bus.id_pc;
    last_rv  = rv;
    @(posedge clk);
    if (rv) e = mq.pop_front();
    if (redir) begin
      epoch++;
      exp_q.delete();
      next_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (rv && e.epoch == epoch) exp_q.push_back(e.addr);
    end
    if (acc) begin
      r.addr = acc_addr; r.epoch = epoch; r.due = cyc + lat;
      if (mq.size() > 0 && r.due <= mq[$].due) r.due = mq[$].due + 1;
      mq.push_back(r);
      if (!redir) next_pc = next_pc + 32'd4;
    end
    spurious = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids got req=%b id=%b exp 0 0", bus.imem_req_valid, bus.id_valid);
    end
    checks++;
    if (bus.id_instr !== 32'h0 || bus.id_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_id_data got instr=%h pc=%h exp 0 0", bus.id_instr, bus.id_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); exp_q.delete();
    next_pc = 32'h0; epoch = 0; cyc = 0; lat = 1; spurious = 1'b0;
    exp_bubble = 0; exp_redir = 0; prev_redir = 1'b0;
  endtask

  task automatic test_stream();
    int pops;
    lat = 1; bus.imem_req_ready = 1'b1; bus.id_ready = 1'b1;
    first_acc = -1; first_valid = -1; pops = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (last_pop) pops++;
    end
    checks++;
    if (first_acc != 0 || first_valid - first_acc != 2) begin
      errors++;
      $display("FAIL first_latency got acc=%0d valid=%0d exp acc=0 valid=2", first_acc, first_valid);
    end
    checks++;
    if (pops < 5) begin
      errors++;
      $display("FAIL stream_progress got pops=%0d exp >=5", pops);
    end
  endtask

  task automatic test_full();
    int accs, pop_cyc, acc_cyc;
    bus.id_ready = 1'b0; lat = 1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    accs = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_acc) accs++;
    end
    checks++;
    if (accs != DEPTH) begin
      errors++;
      $display("FAIL full_cap got accepts=%0d exp %0d", accs, DEPTH);
    end
    bus.id_ready = 1'b1;
    step();
    pop_cyc = cyc - 1;
    bus.id_ready = 1'b0;
    accs = 0; acc_cyc = -1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (last_acc) begin
        accs++;
        if (acc_cyc < 0) acc_cyc = cyc - 1;
      end
    end
    checks++;
    if (accs != 1 || acc_cyc != pop_cyc + 1) begin
      errors++;
      $display("FAIL resume_after_pop got accepts=%0d at=%0d exp 1 at=%0d", accs, acc_cyc, pop_cyc + 1);
    end
  endtask

  task automatic test_redirect_drop();
    int  n;
    logic seen;
    bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1; lat = 3;
    n = 0;
    while (mq.size() < 2 && n < 20) begin step(); n++; end
    checks++;
    if (mq.size() < 2) begin
      errors++;
      $display("FAIL drop_setup got outstanding=%0d exp 2", mq.size());
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 30) begin
      step(); n++;
      if (last_pop) seen = 1'b1;
    end
    checks++;
    if (!seen || last_pop_pc !== 32'h100) begin
      errors++;
      $display("FAIL redirect_first_pc got seen=%b pc=%h exp pc=00000100", seen, last_pop_pc);
    end
  endtask

  task automatic test_redirect_same_cycle();
    int   n;
    logic seen;
    lat = 1; bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    n = 0;
    while (!(mq.size() > 0 && mq[0].due <= cyc) && n < 20) begin step(); n++; end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203;
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (last_rv !== 1'b1) begin
      errors++;
      $display("FAIL redirect_with_rsp got rsp=%b exp 1", last_rv);
    end
    seen = 1'b0; n = 0;
    while (!seen && n < 10) begin
      step(); n++;
      if (last_acc) seen = 1'b1;
    end
    checks++;
    if (!seen || last_acc_addr !== 32'h200) begin
      errors++;
      $display("FAIL restart_addr got seen=%b addr=%h exp 00000200", seen, last_acc_addr);
    end
  endtask

  task automatic test_spurious();
    int held, pops;
    bus.imem_req_ready = 1'b0; bus.id_ready = 1'b0; lat = 1;
    for (int i = 0; i < 8; i++) step();
    held = exp_q.size();
    spurious = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    bus.id_ready = 1'b1; pops = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_pop) pops++;
    end
    checks++;
    if (pops != held) begin
      errors++;
      $display("FAIL spurious_ignored got pops=%0d exp %0d", pops, held);
    end
    bus.imem_req_ready = 1'b1;
  endtask

  task automatic test_random();
    int redir_left;
    redir_left = 0;
    for (int i = 0; i < 600; i++) begin
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      lat                = $urandom_range(1, 4);
      if (redir_left == 0 && $urandom_range(0, 19) == 0) redir_left = $urandom_range(1, 3);
      if (redir_left > 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
        redir_left--;
      end else begin
        bus.redirect_valid = 1'b0;
      end
      step();
    end
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1; bus.id_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    logic [31:0] b0, r0;
    checks++;
    if (perf_bubble_cnt !== 32'(exp_bubble) || perf_redirect_cnt !== 32'(exp_redir)) begin
      errors++;
      $display("FAIL perf_totals got bubble=%0d redir=%0d exp %0d %0d",
               perf_bubble_cnt, perf_redirect_cnt, exp_bubble, exp_redir);
    end
    bus.id_ready = 1'b0; bus.imem_req_ready = 1'b0; bus.redirect_valid = 1'b0;
    step();
    b0 = perf_bubble_cnt; r0 = perf_redirect_cnt;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h500; step();
    bus.redirect_valid = 1'b0; step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h600; step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.id_ready = 1'b0;
    step();
    checks++;
    if (perf_bubble_cnt - b0 !== 32'd5 || perf_redirect_cnt - r0 !== 32'd2) begin
      errors++;
      $display("FAIL perf_scenario got bubble_delta=%0d redir_delta=%0d exp 5 2",
               perf_bubble_cnt - b0, perf_redirect_cnt - r0);
    end
  endtask
`endif

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_spurious();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
